apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of cmd_addr and paddr.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of write/read data.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, max ACCESS cycles before abort.
REQ-004 SHALL have port pclk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port preset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port cmd_valid  in  1  command request.
REQ-007 SHALL have port cmd_ready  out  1  command accepted when both high.
REQ-008 SHALL have port cmd_write  in  1  1=write, 0=read.
REQ-009 SHALL have port cmd_addr  in  ADDR_WIDTH  target address.
REQ-010 SHALL have port cmd_wdata  in  DATA_WIDTH  write data.
REQ-011 SHALL have port paddr  out  ADDR_WIDTH  APB address, also feeds the address decoder.
REQ-012 SHALL have port psel  out  1  master select, drives decoder psel_master.
REQ-013 SHALL have ports penable, pwrite  out  1 each  APB enable/direction.
REQ-014 SHALL have port pwdata  out  DATA_WIDTH  APB write data.
REQ-015 SHALL have ports prdata  in  DATA_WIDTH; pready, pslverr  in  1 each  muxed slave response.
REQ-016 SHALL have port decode_error  in  1  from address decoder, unmapped address.
REQ-017 SHALL have ports rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-018 SHALL have ports rsp_rdata  out  DATA_WIDTH; rsp_status  out  2  (00 OK, 01 SLVERR, 10 DECERR, 11 TIMEOUT).

Function
REQ-019 SHALL implement FSM IDLE, SETUP, ACCESS, RESP; only IDLE asserts cmd_ready.
REQ-020 IDLE: on cmd_valid, SHALL register cmd_addr/cmd_write/cmd_wdata into paddr/pwrite/pwdata and go SETUP.
REQ-021 SETUP: psel=1, penable=0, one cycle; if decode_error=1 -> RESP, status DECERR, rdata 0, no ACCESS phase; else -> ACCESS.
REQ-022 ACCESS: psel=1, penable=1; pready/pslverr sampled only here, ignored in all other states.
REQ-023 ACCESS with pready=1: -> RESP; status SLVERR if pslverr=1 else OK; rsp_rdata=prdata for reads, 0 for writes.
REQ-024 Wait counter SHALL clear on SETUP entry, increment each ACCESS cycle with pready=0; at TIMEOUT_CYCLES ACCESS cycles without pready -> RESP, status TIMEOUT, rdata 0.
REQ-025 pready arriving in the same cycle the count reaches limit SHALL win (normal completion).
REQ-026 paddr/pwrite/pwdata SHALL stay constant from SETUP through last ACCESS cycle; held unchanged in RESP/IDLE.
REQ-027 psel and penable SHALL be 0 in IDLE and RESP.
REQ-028 RESP: rsp_valid=1, rsp_rdata/rsp_status stable until rsp_ready=1; then -> IDLE next cycle.
REQ-029 Latency: command accepted cycle N, SETUP N+1, ACCESS N+2, zero-wait rsp_valid at N+3; new command earliest N+4 after rsp_ready at N+3.
REQ-030 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1); no wrap before limit.

Reset
REQ-031 preset=1 SHALL immediately force state IDLE, psel/penable/pwrite/rsp_valid 0, paddr/pwdata/rsp_rdata 0, rsp_status 00, counter 0.
REQ-032 Reset mid-transfer SHALL abandon the transfer with no response; cmd_ready=1 first cycle after release.

Structure
REQ-033 Shared package apb_pkg SHALL hold FSM state enum, rsp_status code constants, default widths.
REQ-034 No sub-module; wait timer inline; apb_decoder is instantiated beside this block at top level, not inside.

Verification
REQ-035 Write 0x0001_0004/0xDEAD_BEEF, pready=1 first ACCESS -> psel cycle 1, penable cycle 2, rsp_valid cycle 3, status 00.
REQ-036 Read 0x0002_0010, pready after 3 wait states, prdata 0x1234_5678 -> penable high 4 cycles, rsp_rdata 0x1234_5678, status 00.
REQ-037 Read 0x0005_0000, decode_error=1 in SETUP -> penable never high, status 10, rsp_rdata 0.
REQ-038 pready held 0 -> exactly 16 ACCESS cycles then psel=0, status 11.
REQ-039 pready=1 with pslverr=1, rsp_ready low 5 cycles -> status 01, rsp outputs stable, cmd_ready 0 throughout.
REQ-040 preset pulse during ACCESS -> psel/penable 0 same cycle, no rsp_valid, cmd_ready 1 after release.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB master definitions: FSM states, response codes, default widths.
// Imported by the master and by anything consuming its response bundle.
package apb_pkg;

   localparam int APB_ADDR_W  = 32;
   localparam int APB_DATA_W  = 32;
   localparam int APB_TIMEOUT = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } apb_state_e;

   localparam logic [1:0] RSP_OK      = 2'b00;
   localparam logic [1:0] RSP_SLVERR  = 2'b01;
   localparam logic [1:0] RSP_DECERR  = 2'b10;
   localparam logic [1:0] RSP_TIMEOUT = 2'b11;

endpackage

// File: rtl/apb_master.sv
// APB master: one command in, one SETUP/ACCESS transfer out, one response back.
// Aborts with TIMEOUT after TIMEOUT_CYCLES ACCESS cycles without pready.
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH     = APB_ADDR_W,
   parameter int DATA_WIDTH     = APB_DATA_W,
   parameter int TIMEOUT_CYCLES = APB_TIMEOUT
) (
   input  logic                  pclk,
   input  logic                  preset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [DATA_WIDTH-1:0] pwdata,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pready,
   input  logic                  pslverr,
   input  logic                  decode_error,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [1:0]            rsp_status
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   // Last ACCESS cycle that may still complete normally.
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   apb_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic                  pwrite_q, pwrite_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            status_q, status_d;
   logic [CW-1:0]         cnt_q, cnt_d;

   always_comb begin
      state_d  = state_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      pwrite_d = pwrite_q;
      rdata_d  = rdata_q;
      status_d = status_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               paddr_d  = cmd_addr;
               pwdata_d = cmd_wdata;
               pwrite_d = cmd_write;
               cnt_d    = '0;
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (decode_error) begin
               rdata_d  = '0;
               status_d = RSP_DECERR;
               state_d  = ST_RESP;
            end else begin
               state_d  = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            // pready wins even on the cycle the limit is reached.
            if (pready) begin
               rdata_d  = pwrite_q ? '0 : prdata;
               status_d = pslverr ? RSP_SLVERR : RSP_OK;
               state_d  = ST_RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  rdata_d  = '0;
                  status_d = RSP_TIMEOUT;
                  state_d  = ST_RESP;
               end
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_q  <= ST_IDLE;
         paddr_q  <= '0;
         pwdata_q <= '0;
         pwrite_q <= 1'b0;
         rdata_q  <= '0;
         status_q <= RSP_OK;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
         pwrite_q <= pwrite_d;
         rdata_q  <= rdata_d;
         status_q <= status_d;
         cnt_q    <= cnt_d;
      end
   end

   assign cmd_ready  = (state_q == ST_IDLE);
   assign psel       = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
   assign penable    = (state_q == ST_ACCESS);
   assign rsp_valid  = (state_q == ST_RESP);
   assign paddr      = paddr_q;
   assign pwdata     = pwdata_q;
   assign pwrite     = pwrite_q;
   assign rsp_rdata  = rdata_q;
   assign rsp_status = status_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a response scoreboard.
// Emulates the slave and decoder cycle by cycle from the observed bus phase.
module tb_apb_master;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   localparam logic [1:0] E_OK  = 2'b00;
   localparam logic [1:0] E_SLV = 2'b01;
   localparam logic [1:0] E_DEC = 2'b10;
   localparam logic [1:0] E_TMO = 2'b11;

   logic          pclk = 1'b0;
   logic          preset;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr, paddr;
   logic [DW-1:0] cmd_wdata, pwdata, prdata, rsp_rdata;
   logic          psel, penable, pwrite, pready, pslverr;
   logic          decode_error, rsp_valid, rsp_ready;
   logic [1:0]    rsp_status;

   always #5 pclk = ~pclk;

   apb_master #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .pclk(pclk), .preset(preset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .paddr(paddr), .psel(psel),
      .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .decode_error(decode_error), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_status(rsp_status)
   );

   typedef struct packed {
      logic [1:0]    st;
      logic [DW-1:0] rd;
   } rsp_t;

   rsp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic run_cmd(input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata,
                          input logic [DW-1:0] rdv, input int waits,
                          input logic slverr, input logic decerr,
                          input int hold);
      rsp_t       exp;
      rsp_t       got;
      int         exp_acc;
      int         acc = 0;
      int         cyc;
      bit         stable = 1'b1;
      bit         held = 1'b1;
      if (decerr) begin
         exp = '{st: E_DEC, rd: '0};
         exp_acc = 0;
      end else if (waits >= TO) begin
         exp = '{st: E_TMO, rd: '0};
         exp_acc = TO;
      end else begin
         exp.st = slverr ? E_SLV : E_OK;
         exp.rd = wr ? '0 : rdv;
         exp_acc = waits + 1;
      end
      sb.push_back(exp);

      check("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      tick();
      cmd_valid = 1'b0;
      cmd_write = ~wr;
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      cyc = 1;
      check("setup_phase", {psel, penable, cmd_ready}, 3'b100);

      while (!rsp_valid && cyc < 64) begin
         pready       = 1'b0;
         pslverr      = 1'b0;
         decode_error = 1'b0;
         prdata       = $urandom;
         if (psel && (paddr !== addr || pwdata !== wdata || pwrite !== wr))
            stable = 1'b0;
         if (psel && !penable) begin
            decode_error = decerr;
            // Slave response noise in SETUP must be ignored.
            if (!decerr) begin
               pready  = 1'b1;
               pslverr = 1'b1;
            end
         end else if (psel && penable) begin
            acc++;
            if (acc > waits) begin
               pready  = 1'b1;
               pslverr = slverr;
               prdata  = rdv;
            end
         end
         tick();
         cyc++;
      end
      pready       = 1'b0;
      pslverr      = 1'b0;
      decode_error = 1'b0;

      check("rsp_valid_seen", rsp_valid, 1);
      check("latency", cyc, exp_acc + 2);
      check("access_cycles", acc, exp_acc);
      check("addr_stable", stable, 1);
      check("resp_bus_idle", {psel, penable, cmd_ready}, 3'b000);

      if (rsp_valid) begin
         got = sb.pop_front();
         check("rsp_status", rsp_status, got.st);
         check("rsp_rdata", rsp_rdata, got.rd);
         repeat (hold) begin
            prdata = $urandom;
            tick();
            if (!rsp_valid || cmd_ready || psel ||
                rsp_status !== got.st || rsp_rdata !== got.rd)
               held = 1'b0;
         end
         check("rsp_held", held, 1);
         rsp_ready = 1'b1;
         tick();
         rsp_ready = 1'b0;
         check("back_to_idle", {rsp_valid, cmd_ready}, 2'b01);
         check("paddr_held", paddr, addr);
      end
   endtask

   initial begin
      bit quiet;
      preset       = 1'b1;
      cmd_valid    = 1'b0;
      cmd_write    = 1'b0;
      cmd_addr     = '0;
      cmd_wdata    = '0;
      prdata       = '0;
      pready       = 1'b0;
      pslverr      = 1'b0;
      decode_error = 1'b0;
      rsp_ready    = 1'b0;
      repeat (3) tick();
      check("rst_ctrl", {cmd_ready, psel, penable, pwrite, rsp_valid},
            5'b10000);
      check("rst_paddr", paddr, 0);
      check("rst_pwdata", pwdata, 0);
      check("rst_rdata", rsp_rdata, 0);
      check("rst_status", rsp_status, 0);
      preset = 1'b0;
      tick();

      run_cmd(1'b1, 32'h0001_0004, 32'hDEAD_BEEF, 32'hCAFE_0001,
              0, 1'b0, 1'b0, 0);
      run_cmd(1'b0, 32'h0002_0010, 32'h0, 32'h1234_5678,
              3, 1'b0, 1'b0, 0);
      run_cmd(1'b0, 32'h0005_0000, 32'h0, 32'h5555_AAAA,
              0, 1'b0, 1'b1, 0);
      run_cmd(1'b0, 32'h0003_0000, 32'h0, 32'h7777_7777,
              1000, 1'b0, 1'b0, 2);
      run_cmd(1'b0, 32'h0003_0040, 32'h0, 32'hA5A5_0F0F,
              TO - 1, 1'b0, 1'b0, 0);
      run_cmd(1'b1, 32'h0004_0008, 32'h0BAD_F00D, 32'hFFFF_FFFF,
              1, 1'b1, 1'b0, 5);
      run_cmd(1'b0, 32'h0004_000C, 32'h0, 32'h8765_4321,
              0, 1'b1, 1'b0, 1);

      // Reset pulse in the middle of an ACCESS phase.
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'h0006_0000;
      cmd_wdata = 32'h1111_2222;
      tick();
      cmd_valid = 1'b0;
      tick();
      check("pre_rst_access", {psel, penable}, 2'b11);
      #2 preset = 1'b1;
      #1;
      check("async_rst_bus", {psel, penable, rsp_valid}, 3'b000);
      check("async_rst_paddr", paddr, 0);
      tick();
      preset = 1'b0;
      tick();
      check("rst_release_ready", cmd_ready, 1);
      quiet = 1'b1;
      repeat (5) begin
         if (rsp_valid || psel) quiet = 1'b0;
         tick();
      end
      check("no_rsp_after_rst", quiet, 1);

      run_cmd(1'b0, 32'h0007_0004, 32'h0, 32'h0F1E_2D3C,
              2, 1'b0, 1'b0, 0);
      check("scoreboard_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
